// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice front end: command layout,
// STOP_ALL encoding, allocator FSM states and status-register fields.
package synth_pkg;

    localparam int CMD_W    = 16;
    localparam int ON_BIT   = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 8;
    localparam int VEL_MSB  = 7;

    localparam logic [6:0] STOP_ALL_NOTE = 7'd127;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POP   = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_APPLY = 2'd3;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_LEVEL_LSB = 16;
    localparam int STAT_LEVEL_W   = 8;
    localparam int STAT_MASK_W    = 16;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [7:0] vel;
    } note_cmd_t;

    function automatic note_cmd_t decode_cmd(input logic [CMD_W-1:0] raw);
        note_cmd_t c;
        c.on   = raw[ON_BIT];
        c.note = raw[NOTE_MSB:NOTE_LSB];
        c.vel  = raw[VEL_MSB:0];
        return c;
    endfunction

    // A note-off addressed to the top note means "silence everything".
    function automatic logic is_stop_all(input note_cmd_t c);
        return !c.on && (c.note == STOP_ALL_NOTE);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO buffering note commands; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array is deliberately not reset; count alone says
    // which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/voice_allocator_p.sv
// Polyphonic voice allocator: buffers note commands, scans the voices one
// per cycle and applies retrigger / free-voice / oldest-steal / stop-all.
module voice_allocator_p
    import synth_pkg::*;
#(
    parameter int N_VOICES   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NOTE_W     = 7,
    parameter int VEL_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       avs_s0_write,
    input  logic                       avs_s0_read,
    input  logic [31:0]                avs_s0_writedata,
    output logic [31:0]                avs_s0_readdata,
    output logic [N_VOICES-1:0]        o_voice_active,
    output logic [N_VOICES*NOTE_W-1:0] o_voice_note,
    output logic [N_VOICES*VEL_W-1:0]  o_voice_vel,
    output logic [N_VOICES-1:0]        o_voice_trig,
    output logic                       o_busy,
    output logic                       o_overflow
);
    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);
    localparam logic [IDX_W-1:0] AGE_MAX  = LAST_IDX;

    logic [1:0]       state;
    logic [1:0]       state_next;
    note_cmd_t        cmd_q;
    note_cmd_t        head_cmd;
    logic [IDX_W-1:0] scan_idx;
    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             old_found;
    logic [IDX_W-1:0] old_idx;
    logic [IDX_W-1:0] old_age;

    logic [N_VOICES-1:0] voice_active;
    logic [NOTE_W-1:0]   voice_note [N_VOICES];
    logic [VEL_W-1:0]    voice_vel  [N_VOICES];
    logic [IDX_W-1:0]    voice_age  [N_VOICES];

    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_pop;
    logic             drop;
    logic             write_accept;
    logic [NOTE_W-1:0] cmd_note;
    logic             target_valid;
    logic [IDX_W-1:0] target;
    logic [31:0]      status_word;
    logic             unused_hi;

    assign unused_hi    = ^avs_s0_writedata[31:16];
    assign fifo_pop     = (state == ST_POP);
    assign drop         = avs_s0_write && fifo_full && !fifo_pop;
    assign write_accept = avs_s0_write && !drop;
    assign head_cmd     = decode_cmd(fifo_dout);
    assign cmd_note     = NOTE_W'(cmd_q.note);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (avs_s0_write),
        .pop   (fifo_pop),
        .din   (avs_s0_writedata[CMD_W-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (latch).
    always_comb begin
        state_next = state;
        case (state)
            // A write landing this cycle also wakes the FSM, saving one idle cycle.
            ST_IDLE:  if (!fifo_empty || write_accept) state_next = ST_POP;
            ST_POP:   state_next = is_stop_all(head_cmd) ? ST_APPLY : ST_SCAN;
            ST_SCAN:  if (scan_idx == LAST_IDX) state_next = ST_APPLY;
            ST_APPLY: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Voice chosen by the scan: match first, then free, then oldest.
    always_comb begin
        target_valid = 1'b0;
        target       = '0;
        if (cmd_q.on) begin
            target_valid = 1'b1;
            if (match_found)     target = match_idx;
            else if (free_found) target = free_idx;
            else                 target = old_idx;
        end else if (match_found) begin
            target_valid = 1'b1;
            target       = match_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_found   <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_POP: begin
                    cmd_q       <= head_cmd;
                    scan_idx    <= '0;
                    match_found <= 1'b0;
                    free_found  <= 1'b0;
                    old_found   <= 1'b0;
                end
                ST_SCAN: begin
                    if (voice_active[scan_idx] && !match_found
                        && voice_note[scan_idx] == cmd_note) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!voice_active[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (voice_active[scan_idx]
                        && (!old_found || voice_age[scan_idx] > old_age)) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_age   <= voice_age[scan_idx];
                    end
                    if (scan_idx != LAST_IDX) scan_idx <= scan_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            voice_active <= '0;
            o_voice_trig <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                voice_note[i] <= '0;
                voice_vel[i]  <= '0;
                voice_age[i]  <= '0;
            end
        end else begin
            o_voice_trig <= '0;
            if (state == ST_APPLY) begin
                if (is_stop_all(cmd_q)) begin
                    voice_active <= '0;
                    for (int i = 0; i < N_VOICES; i++) voice_age[i] <= '0;
                end else if (cmd_q.on) begin
                    for (int i = 0; i < N_VOICES; i++) begin
                        if (IDX_W'(i) == target) begin
                            voice_active[i] <= 1'b1;
                            voice_note[i]   <= cmd_note;
                            voice_vel[i]    <= VEL_W'(cmd_q.vel);
                            voice_age[i]    <= '0;
                            o_voice_trig[i] <= 1'b1;
                        end else if (voice_active[i] && voice_age[i] != AGE_MAX) begin
                            voice_age[i] <= voice_age[i] + 1'b1;
                        end
                    end
                end else if (target_valid) begin
                    voice_active[target] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_OVF_BIT] = o_overflow;
        status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
        for (int i = 0; i < N_VOICES && i < STAT_MASK_W; i++) begin
            status_word[i] = voice_active[i];
        end
    end

    // A drop in the same cycle as a read keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_overflow      <= 1'b0;
            avs_s0_readdata <= '0;
        end else begin
            if (drop)             o_overflow <= 1'b1;
            else if (avs_s0_read) o_overflow <= 1'b0;
            if (avs_s0_read) avs_s0_readdata <= status_word;
        end
    end

    always_comb begin
        o_voice_note = '0;
        o_voice_vel  = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            o_voice_note[i*NOTE_W +: NOTE_W] = voice_note[i];
            o_voice_vel[i*VEL_W +: VEL_W]    = voice_vel[i];
        end
    end

    assign o_voice_active = voice_active;
    assign o_busy         = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_voice_allocator_p.sv
// Self-checking bench for voice_allocator_p: directed scenarios plus random
// commands compared against a list-level voice allocation model.
module tb_voice_allocator_p;

    localparam int N  = 8;
    localparam int NW = 7;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          avs_s0_write;
    logic          avs_s0_read;
    logic [31:0]   avs_s0_writedata;
    logic [31:0]   avs_s0_readdata;
    logic [N-1:0]  o_voice_active;
    logic [N*NW-1:0] o_voice_note;
    logic [N*VW-1:0] o_voice_vel;
    logic [N-1:0]  o_voice_trig;
    logic          o_busy;
    logic          o_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_active [N];
    int m_note   [N];
    int m_vel    [N];
    int m_age    [N];
    logic [N-1:0] last_trig;

    voice_allocator_p #(
        .N_VOICES   (N),
        .FIFO_DEPTH (4),
        .NOTE_W     (NW),
        .VEL_W      (VW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_readdata  (avs_s0_readdata),
        .o_voice_active   (o_voice_active),
        .o_voice_note     (o_voice_note),
        .o_voice_vel      (o_voice_vel),
        .o_voice_trig     (o_voice_trig),
        .o_busy           (o_busy),
        .o_overflow       (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0;
            m_note[i]   = 0;
            m_vel[i]    = 0;
            m_age[i]    = 0;
        end
    endtask

    function automatic logic [N-1:0] model_active_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_active[i];
        return v;
    endfunction

    function automatic logic [N*NW-1:0] model_note_vec();
        logic [N*NW-1:0] v;
        for (int i = 0; i < N; i++) v[i*NW +: NW] = NW'(m_note[i]);
        return v;
    endfunction

    function automatic logic [N*VW-1:0] model_vel_vec();
        logic [N*VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*VW +: VW] = VW'(m_vel[i]);
        return v;
    endfunction

    // Allocation rules: retrigger a sounding note, else lowest free voice,
    // else the voice that has sounded longest (lowest index on a tie).
    task automatic model_apply(input logic [15:0] c, output logic [N-1:0] exp_trig);
        int note, vel, match, tgt;
        bit on;
        on   = c[15];
        note = int'(c[14:8]);
        vel  = int'(c[7:0]);
        exp_trig = '0;
        if (!on && note == 127) begin
            for (int i = 0; i < N; i++) begin
                m_active[i] = 0;
                m_age[i]    = 0;
            end
        end else begin
            match = -1;
            for (int i = 0; i < N; i++)
                if (match < 0 && m_active[i] && m_note[i] == note) match = i;
            if (!on) begin
                if (match >= 0) m_active[match] = 0;
            end else begin
                tgt = match;
                for (int i = 0; i < N; i++)
                    if (tgt < 0 && !m_active[i]) tgt = i;
                if (tgt < 0) begin
                    tgt = 0;
                    for (int i = 1; i < N; i++)
                        if (m_age[i] > m_age[tgt]) tgt = i;
                end
                for (int i = 0; i < N; i++)
                    if (i != tgt && m_active[i] && m_age[i] < N - 1) m_age[i]++;
                m_active[tgt] = 1;
                m_note[tgt]   = note;
                m_vel[tgt]    = vel;
                m_age[tgt]    = 0;
                exp_trig[tgt] = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        avs_s0_write = 1'b0;
        avs_s0_read  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    // Writes one command into an idle allocator and checks the voices stay
    // unchanged until the expected edge, then match the model there.
    task automatic do_cmd(input logic [15:0] c, input string tag);
        logic [N-1:0]    old_act, exp_trig;
        logic [N*NW-1:0] old_note;
        logic [N*VW-1:0] old_vel;
        int lat;
        lat = (!c[15] && c[14:8] == 7'd127) ? 2 : N + 2;
        old_act  = model_active_vec();
        old_note = model_note_vec();
        old_vel  = model_vel_vec();
        model_apply(c, exp_trig);
        avs_s0_write     = 1'b1;
        avs_s0_writedata = {16'($urandom), c};
        tick();
        avs_s0_write = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == lat - 1) begin
                checks++;
                if (o_voice_active !== old_act || o_voice_note !== old_note
                    || o_voice_vel !== old_vel || o_voice_trig !== '0) begin
                    errors++;
                    $display("FAIL %s early_change: active=%h trig=%h, expected active=%h trig=0",
                             tag, o_voice_active, o_voice_trig, old_act);
                end
            end
        end
        last_trig = o_voice_trig;
        checks++;
        if (o_voice_active !== model_active_vec()) begin
            errors++;
            $display("FAIL %s active: got %h expected %h", tag, o_voice_active, model_active_vec());
        end
        checks++;
        if (o_voice_note !== model_note_vec() || o_voice_vel !== model_vel_vec()) begin
            errors++;
            $display("FAIL %s note_vel: got %h/%h expected %h/%h", tag, o_voice_note,
                     o_voice_vel, model_note_vec(), model_vel_vec());
        end
        checks++;
        if (o_voice_trig !== exp_trig) begin
            errors++;
            $display("FAIL %s trig: got %h expected %h", tag, o_voice_trig, exp_trig);
        end
        tick();
        checks++;
        if (o_voice_trig !== '0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s trig_clear_busy: trig=%h busy=%b expected 0/0", tag, o_voice_trig, o_busy);
        end
    endtask

    task automatic do_read(output logic [31:0] data);
        avs_s0_read = 1'b1;
        tick();
        avs_s0_read = 1'b0;
        data = avs_s0_readdata;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        avs_s0_write = 1'b0;
        avs_s0_read  = 1'b0;
        avs_s0_writedata = '0;
        repeat (3) tick();
        checks++;
        if (o_voice_active !== '0 || o_voice_trig !== '0 || o_voice_note !== '0 || o_voice_vel !== '0) begin
            errors++;
            $display("FAIL reset_voices: active=%h trig=%h note=%h vel=%h expected all 0",
                     o_voice_active, o_voice_trig, o_voice_note, o_voice_vel);
        end
        checks++;
        if (avs_s0_readdata !== '0 || o_busy !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: readdata=%h busy=%b ovf=%b expected 0", avs_s0_readdata, o_busy, o_overflow);
        end
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_single_note();
        logic [31:0] rd;
        do_cmd(16'hDB40, "single");
        checks++;
        if (last_trig !== 8'h01 || o_voice_note[0 +: NW] !== 7'd91 || o_voice_vel[0 +: VW] !== 8'h40) begin
            errors++;
            $display("FAIL single_voice0: trig=%h note=%0d vel=%h expected 01/91/40",
                     last_trig, o_voice_note[0 +: NW], o_voice_vel[0 +: VW]);
        end
        do_read(rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++;
            $display("FAIL single_status: got %h expected 00000001", rd);
        end
    endtask

    task automatic test_note_off();
        do_cmd(16'hBC7F, "off_on60");
        checks++;
        if (last_trig !== 8'h02 || o_voice_note[NW +: NW] !== 7'd60 || o_voice_vel[VW +: VW] !== 8'h7F) begin
            errors++;
            $display("FAIL off_voice1: trig=%h note=%0d vel=%h expected 02/60/7f",
                     last_trig, o_voice_note[NW +: NW], o_voice_vel[VW +: VW]);
        end
        do_cmd(16'h5B00, "off_91");
        checks++;
        if (o_voice_active !== 8'h02 || o_voice_note[0 +: NW] !== 7'd91) begin
            errors++;
            $display("FAIL off_release: active=%h note0=%0d expected 02/91", o_voice_active, o_voice_note[0 +: NW]);
        end
        do_cmd(16'h5B00, "off_again");
        checks++;
        if (o_voice_active !== 8'h02 || last_trig !== '0) begin
            errors++;
            $display("FAIL off_nomatch: active=%h trig=%h expected 02/00", o_voice_active, last_trig);
        end
    endtask

    task automatic test_retrigger();
        apply_reset();
        for (int n = 0; n < 2; n++) begin
            do_cmd(16'hDB40, "retrig");
            checks++;
            if (last_trig !== 8'h01 || o_voice_active !== 8'h01) begin
                errors++;
                $display("FAIL retrig_%0d: trig=%h active=%h expected 01/01", n, last_trig, o_voice_active);
            end
        end
    endtask

    task automatic test_steal();
        apply_reset();
        for (int n = 40; n <= 48; n++) do_cmd({1'b1, 7'(n), 8'(n + 1)}, "steal");
        checks++;
        if (last_trig !== 8'h01 || o_voice_active !== 8'hFF || o_voice_note[0 +: NW] !== 7'd48) begin
            errors++;
            $display("FAIL steal_oldest: trig=%h active=%h note0=%0d expected 01/ff/48",
                     last_trig, o_voice_active, o_voice_note[0 +: NW]);
        end
    endtask

    task automatic test_stop_all();
        do_cmd(16'h7F00, "stop");
        checks++;
        if (o_voice_active !== '0 || last_trig !== '0) begin
            errors++;
            $display("FAIL stop_all: active=%h trig=%h expected 00/00", o_voice_active, last_trig);
        end
        do_cmd(16'hBC40, "after_stop");
        checks++;
        if (last_trig !== 8'h01 || o_voice_note[0 +: NW] !== 7'd60) begin
            errors++;
            $display("FAIL after_stop: trig=%h note0=%0d expected 01/60", last_trig, o_voice_note[0 +: NW]);
        end
    endtask

    task automatic test_random();
        int r, note;
        logic on;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            r    = $urandom_range(0, 12);
            note = (r == 12) ? 127 : 60 + r;
            on   = ($urandom_range(0, 2) != 0);
            do_cmd({on, 7'(note), 8'($urandom)}, "random");
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        avs_s0_write = 1'b1;
        avs_s0_writedata = 32'h0000_C050;
        tick();
        avs_s0_writedata = 32'h0000_C160;
        tick();
        avs_s0_write = 1'b0;
        for (int e = 2; e <= 21; e++) begin
            tick();
            if (e == 10) begin
                checks++;
                if (o_voice_active !== 8'h01 || o_voice_trig !== 8'h01 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first: active=%h trig=%h busy=%b expected 01/01/1",
                             o_voice_active, o_voice_trig, o_busy);
                end
            end
            if (e == 20) begin
                checks++;
                if (o_voice_active !== 8'h01) begin
                    errors++;
                    $display("FAIL b2b_early: active=%h expected 01", o_voice_active);
                end
            end
        end
        checks++;
        if (o_voice_active !== 8'h03 || o_voice_trig !== 8'h02 || o_voice_note[NW +: NW] !== 7'd65) begin
            errors++;
            $display("FAIL b2b_second: active=%h trig=%h note1=%0d expected 03/02/65",
                     o_voice_active, o_voice_trig, o_voice_note[NW +: NW]);
        end
        tick();
    endtask

    task automatic test_overflow_and_reset();
        apply_reset();
        avs_s0_write = 1'b1;
        avs_s0_writedata = 32'h0000_DB40;
        tick();
        for (int e = 1; e <= 15; e++) begin
            avs_s0_write     = (e >= 2 && e <= 8);
            avs_s0_writedata = {16'h0, 1'b1, 7'(30 + e), 8'h10};
            avs_s0_read      = (e == 7 || e == 9 || e == 10);
            reset            = (e == 15) ? 1'b0 : 1'b1;
            tick();
            avs_s0_write = 1'b0;
            avs_s0_read  = 1'b0;
            case (e)
                5: begin
                    checks++;
                    if (o_overflow !== 1'b0) begin
                        errors++;
                        $display("FAIL ovf_before_full: got %b expected 0", o_overflow);
                    end
                end
                6: begin
                    checks++;
                    if (o_overflow !== 1'b1) begin
                        errors++;
                        $display("FAIL ovf_set: got %b expected 1", o_overflow);
                    end
                end
                7: begin
                    checks++;
                    if (o_overflow !== 1'b1 || avs_s0_readdata !== 32'h8004_0000) begin
                        errors++;
                        $display("FAIL ovf_drop_wins: ovf=%b readdata=%h expected 1/80040000",
                                 o_overflow, avs_s0_readdata);
                    end
                end
                9: begin
                    checks++;
                    if (o_overflow !== 1'b0 || avs_s0_readdata !== 32'h8004_0000) begin
                        errors++;
                        $display("FAIL ovf_read_clear: ovf=%b readdata=%h expected 0/80040000",
                                 o_overflow, avs_s0_readdata);
                    end
                end
                10: begin
                    checks++;
                    if (avs_s0_readdata !== 32'h0004_0000 || o_voice_active !== 8'h01) begin
                        errors++;
                        $display("FAIL ovf_second_read: readdata=%h active=%h expected 00040000/01",
                                 avs_s0_readdata, o_voice_active);
                    end
                end
                15: begin
                    checks++;
                    if (o_voice_active !== '0 || o_voice_note !== '0 || o_voice_vel !== '0
                        || o_voice_trig !== '0 || o_busy !== 1'b0 || o_overflow !== 1'b0
                        || avs_s0_readdata !== '0) begin
                        errors++;
                        $display("FAIL mid_scan_reset: active=%h busy=%b ovf=%b readdata=%h expected all 0",
                                 o_voice_active, o_busy, o_overflow, avs_s0_readdata);
                    end
                end
                default: ;
            endcase
        end
        reset = 1'b1;
        model_reset();
        repeat (12) tick();
        checks++;
        if (o_busy !== 1'b0 || o_voice_active !== '0 || o_voice_trig !== '0) begin
            errors++;
            $display("FAIL reset_discard: busy=%b active=%h expected 0/00", o_busy, o_voice_active);
        end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_note_off();
        test_retrigger();
        test_steal();
        test_stop_all();
        test_random();
        test_back_to_back();
        test_overflow_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator_p.md
Name: voice_allocator_p

Overview:
Parametrised polyphonic note-command front end that sits between the Avalon-MM slave and the oscillator bank in the synthesizer top.
- Buffers 16-bit note commands in a small FIFO: bit15 on/off, bits14:8 note, bits7:0 velocity.
- Assigns each note-on to one of N_VOICES voices. Same-note retrigger, oldest-voice stealing and stop-all are supported.
- Exposes per-voice note, velocity, active and trigger outputs to the oscillators, plus a status register on readdata.

Parameters:
- N_VOICES, 8, number of voices; legal range 1..16.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- NOTE_W, 7, note field width.
- VEL_W, 8, velocity field width.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- reset  in  1  reset; synchronous and active-low.
- avs_s0_write  in  1  write strobe; one command per asserted cycle.
- avs_s0_read  in  1  status read strobe.
- avs_s0_writedata  in  32  command in bits 15:0; bits 31:16 are ignored.
- avs_s0_readdata  out  32  status: [31] overflow, [30:24] 0, [23:16] FIFO level, [15:0] active mask (zero-extended).
- o_voice_active  out  N_VOICES  voice gate.
- o_voice_note  out  N_VOICES*NOTE_W  note per voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
- o_voice_vel  out  N_VOICES*VEL_W  velocity per voice.
- o_voice_trig  out  N_VOICES  one-cycle pulse when a voice is (re)started.
- o_busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- o_overflow  out  1  sticky flag: a command was dropped.

Behaviour:
- Reset (reset==0 at a clk edge), including mid-operation:
  - FIFO is emptied, FSM goes to IDLE.
  - All voice registers, ages, o_voice_trig, readdata, o_busy and o_overflow are cleared to 0.
  - Any command in flight is discarded.
- FIFO push:
  - A write is pushed on the edge where it is sampled.
  - A write while the FIFO is full is dropped and sets overflow, unless a pop occurs in the same cycle; in that case the write is accepted.
- Status read:
  - readdata is registered and valid the cycle after avs_s0_read.
  - A read clears overflow on the same edge. A drop in that same cycle wins, so overflow stays set.
- FSM states: IDLE, POP, SCAN, APPLY.
  - IDLE: if the FIFO is non-empty, go to POP.
  - POP: pop the head into the command register.
    - If the command is off and note==127 (STOP_ALL), go to APPLY.
    - Otherwise go to SCAN, index=0.
  - SCAN: one voice per cycle, index 0..N_VOICES-1, recording three things:
    - first active voice with a matching note;
    - lowest-index inactive voice;
    - oldest active voice (maximum age, ties to the lowest index).
    - After index N_VOICES-1, go to APPLY.
  - APPLY: update the voice registers, then go to IDLE. The next command is popped no earlier than the following cycle.
- Latency, idle FSM and empty FIFO:
  - Normal command: voice outputs change on edge N_VOICES+2 after the write edge.
  - STOP_ALL: voice outputs change on edge 2.
- APPLY, note-on (priority order):
  1. Matching active voice: retrigger it (new velocity, trig pulse).
  2. Else free voice: lowest-index free voice gets active=1, note, velocity and a trig pulse.
  3. Else steal the oldest voice: overwrite note and velocity, trig pulse.
  - The chosen voice gets age=0. Every other active voice's age increments, saturating at N_VOICES-1.
  - Velocity 0 is a legal note-on.
- APPLY, note-off:
  - Matching voice: active=0; note, velocity and age are held.
  - No match: no change, no error.
- APPLY, STOP_ALL: all active bits=0, ages=0, no trig.
- Note-on with note 127 is a normal note.
- o_voice_trig is high only in the cycle after APPLY; at most one bit is set.
- o_voice_note and o_voice_vel are held while a voice is inactive.

Decomposition:
- synth_pkg holds:
  - command bit positions (ON_BIT=15, NOTE_MSB=14, NOTE_LSB=8, VEL_MSB=7);
  - STOP_ALL_NOTE=127;
  - FSM state encoding;
  - status-register field positions.
- Sub-module cmd_fifo: synchronous FIFO with parameters DEPTH and WIDTH=16, outputs full, empty and level, active-low sync reset.
- Allocation and FSM logic stay in voice_allocator_p.

Test Plan:
1. Reset, then write 0x0000DB40 → after 10 cycles (N_VOICES=8): voice0 active, note 91, vel 0x40; trig=0x01 for exactly 1 cycle; readdata active mask=0x0001.
2. Write 0xBC7F, then 0x5B00 → voice1 takes note 60 vel 0x7F; voice0 then goes inactive; voice1 is unaffected; a second 0x5B00 changes nothing.
3. Write 0xDB40 twice → only voice0 is used, trig[0] pulses twice, active mask stays 0x0001.
4. Write 9 distinct note-ons, notes 40..48 → notes 40..47 fill voices 0..7; note 48 steals voice0 (trig[0]); mask stays 0x00FF.
5. With voices playing, write 0x7F00 → all active bits are 0 on edge 2, no trig. Then write 0xBC40 → voice0 is allocated.
6. Write FIFO_DEPTH+3 commands back-to-back during a SCAN → extra writes are dropped and o_overflow=1. First read returns bit31=1, a second read returns bit31=0. Assert reset mid-SCAN → all outputs 0 next cycle.
